// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller states and default latencies.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mult_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational arithmetic core: produces {hi,lo} from the latched operands
// and operation. Signed division runs on magnitudes and re-applies the signs.
module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  md_op_e      op_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        // Low 64 bits of a product of sign-extended operands equal the signed product.
        prod_s   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u   = {32'd0, a_i} * {32'd0, b_i};
        sgn      = (op_i == MD_DIV);
        num      = (sgn && a_i[31]) ? -a_i : a_i;
        den      = (sgn && b_i[31]) ? -b_i : b_i;
        den_safe = (den == 32'd0) ? 32'd1 : den;
        uq       = num / den_safe;
        ur       = num % den_safe;
        hi_o     = 32'd0;
        lo_o     = 32'd0;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prod_s;
            MD_MULTU: {hi_o, lo_o} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b_i == 32'd0) begin
                    lo_o = 32'hFFFF_FFFF;
                    hi_o = a_i;
                end else begin
                    // 0x80000000 / -1 falls out naturally: magnitude 2^31, no negation.
                    lo_o = (sgn && (a_i[31] ^ b_i[31])) ? -uq : uq;
                    hi_o = (sgn && a_i[31]) ? -ur : ur;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; an IDLE/BUSY
// controller and down-counter model the fixed operation latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    md_op_e            op_q, op_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    md_op_e            op_in;

    assign op_in = md_op_e'(MDOp);

    md_compute u_compute (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .hi_o (res_hi),
        .lo_o (res_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_mult_op(op_in) || is_div_op(op_in)) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op_in;
                        cnt_d   = is_mult_op(op_in) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d = ST_BUSY;
                    end else if (op_in == MD_MTHI) begin
                        hi_d = A;
                    end else if (op_in == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_BUSY: begin
                // Start is deliberately not looked at here: requests while busy are dropped.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
